// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: immediate format codes and the result record shared by the
// immediate-extension pipeline and its formatter.
`default_nettype none

package imm_ext_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_B   = 3'b010,
    FMT_J   = 3'b011,
    FMT_U   = 3'b100,
    FMT_Z   = 3'b101,
    FMT_SH  = 3'b110,
    FMT_RSV = 3'b111
  } imm_fmt_e;

  typedef logic [MAX_XLEN-1:0] word_t;

  // Sized for the widest datapath; narrower builds keep the upper bits at zero.
  typedef struct packed {
    word_t imm;
    word_t target;
    logic  illegal;
  } imm_res_t;

endpackage

`default_nettype wire

// File: rtl/imm_ext_fmt.sv
// imm_ext_fmt: purely combinational immediate extraction and extension.
// instr carries instruction bits [31:7], so instr[k] is instruction bit k+7.
`default_nettype none

module imm_ext_fmt
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_fmt_e    fmt;
  logic        sgn;
  logic [31:0] imm32;

  assign fmt = imm_fmt_e'(src);
  assign sgn = instr[24];

  // Every format is first assembled as a 32-bit value whose bit 31 is the
  // correct extension bit, so one signed cast widens all of them.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:   imm32 = {{20{sgn}}, instr[24:13]};
      FMT_S:   imm32 = {{20{sgn}}, instr[24:18], instr[4:0]};
      FMT_B:   imm32 = {{19{sgn}}, instr[24], instr[0], instr[23:18],
                        instr[4:1], 1'b0};
      FMT_J:   imm32 = {{11{sgn}}, instr[24], instr[12:5], instr[13],
                        instr[23:14], 1'b0};
      FMT_U:   imm32 = {instr[24:5], 12'b0};
      FMT_Z:   imm32 = {27'b0, instr[12:8]};
      FMT_SH:  imm32 = (XLEN == 64) ? {26'b0, instr[18:13]}
                                    : {27'b0, instr[17:13]};
      FMT_RSV: begin
        imm32   = '0;
        illegal = 1'b1;
      end
      default: begin
        imm32   = '0;
        illegal = 1'b0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: one-cycle immediate extension and branch-target adder behind
// a two-entry skid buffer with valid/ready handshakes on both sides.
`default_nettype none

module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] fmt_imm;
  logic            fmt_illegal;
  logic [XLEN-1:0] fmt_target;
  imm_res_t        in_res;

  imm_ext_fmt #(
    .XLEN(XLEN)
  ) u_fmt (
    .instr  (in_instr),
    .src    (in_imm_src),
    .imm    (fmt_imm),
    .illegal(fmt_illegal)
  );

  // Modulo-XLEN sum; reserved formats give imm 0, so target falls back to pc.
  assign fmt_target = in_pc + fmt_imm;

  assign in_res = '{imm:     word_t'(fmt_imm),
                    target:  word_t'(fmt_target),
                    illegal: fmt_illegal};

  logic     main_valid;
  logic     skid_valid;
  imm_res_t main_q;
  imm_res_t skid_q;
  logic     in_fire;
  logic     out_fire;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & ~skid_valid;
  assign out_fire = main_valid & out_ready;

  // The skid slot only fills while main is held, so it is always the older
  // entry and must be promoted before any new input reaches main.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_q <= in_res;
        end
      end
    end else if (in_fire) begin
      skid_q     <= in_res;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_target  = main_q.target[XLEN-1:0];
  assign out_illegal = main_q.illegal;

  if (XLEN < MAX_XLEN) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.imm[MAX_XLEN-1:XLEN],
                         main_q.target[MAX_XLEN-1:XLEN]};
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench driving an XLEN=32 and an XLEN=64
// instance of imm_ext_pipe with identical handshakes.
`default_nettype none

module tb_imm_ext_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] target;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [63:0] pc64;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rnd_rdy  = 1'b0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_pc(pc64[31:0]),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_illegal(ill32)
  );

  imm_ext_pipe #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_pc(pc64),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_illegal(ill64)
  );

  // Reference model: fields pulled out of the full instruction word by shifts.
  function automatic exp_t model(input logic [31:0] instr, input logic [2:0] src,
                                 input logic [63:0] pc, input int xlen);
    exp_t r;
    logic signed [63:0] sx;
    logic [63:0] hi, imm, mask;
    sx = {{32{instr[31]}}, instr};
    hi = sx >>> 31;
    case (src)
      3'd0: imm = sx >>> 20;
      3'd1: begin hi = sx >>> 25; imm = (hi << 5) | 64'(instr[11:7]); end
      3'd2: imm = (hi << 12) | (64'(instr[7]) << 11) | (64'(instr[30:25]) << 5)
                | (64'(instr[11:8]) << 1);
      3'd3: imm = (hi << 20) | (64'(instr[19:12]) << 12) | (64'(instr[20]) << 11)
                | (64'(instr[30:21]) << 1);
      3'd4: imm = sx & ~64'hFFF;
      3'd5: imm = 64'(instr[19:15]);
      3'd6: imm = (xlen == 64) ? 64'(instr[25:20]) : 64'(instr[24:20]);
      default: imm = 64'd0;
    endcase
    mask = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    r.imm     = imm & mask;
    r.target  = (pc + imm) & mask;
    r.illegal = (src == 3'd7);
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (ov32 && out_ready) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++;
          $display("FAIL sb32_extra: got imm=%h with no entry pending", imm32);
        end else begin
          e = q32.pop_front();
          if ({imm32, tgt32, ill32} !== {e.imm[31:0], e.target[31:0], e.illegal}) begin
            n_fail++;
            $display("FAIL sb32: got imm=%h tgt=%h ill=%b exp imm=%h tgt=%h ill=%b",
                     imm32, tgt32, ill32, e.imm[31:0], e.target[31:0], e.illegal);
          end
        end
      end
      if (ov64 && out_ready) begin
        n_checks++;
        if (q64.size() == 0) begin
          n_fail++;
          $display("FAIL sb64_extra: got imm=%h with no entry pending", imm64);
        end else begin
          e = q64.pop_front();
          if ({imm64, tgt64, ill64} !== {e.imm, e.target, e.illegal}) begin
            n_fail++;
            $display("FAIL sb64: got imm=%h tgt=%h ill=%b exp imm=%h tgt=%h ill=%b",
                     imm64, tgt64, ill64, e.imm, e.target, e.illegal);
          end
        end
      end
      if (in_valid && rdy32) q32.push_back(model({in_instr, 7'b0}, in_imm_src, pc64, 32));
      if (in_valid && rdy64) q64.push_back(model({in_instr, 7'b0}, in_imm_src, pc64, 64));
    end
  end

  task automatic send(input logic [31:0] instr, input logic [2:0] src,
                      input logic [63:0] pc);
    bit done = 1'b0;
    bit rdy;
    in_valid   = 1'b1;
    in_instr   = instr[31:7];
    in_imm_src = src;
    pc64       = pc;
    for (int t = 0; t < 64 && !done; t++) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      rdy = rdy32;
      @(posedge clk); #1;
      done = rdy;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after 64 cycles, required 1", rdy32);
    end
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 64 && (q32.size() != 0 || q64.size() != 0); t++) @(posedge clk);
    #1; @(posedge clk); #1;
    n_checks++;
    if (q32.size() != 0 || q64.size() != 0 || ov32 || ov64) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d/%0d out_valid=%b%b, required 0/0 00",
               tag, q32.size(), q64.size(), ov32, ov64);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_imm_src = '0; pc64 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, rdy32, imm32, tgt32, ill32} !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset32: valid=%b ready=%b imm=%h tgt=%h ill=%b, required 0 1 0 0 0",
               ov32, rdy32, imm32, tgt32, ill32);
    end
    n_checks++;
    if ({ov64, rdy64, imm64, tgt64, ill64} !== {1'b0, 1'b1, 64'd0, 64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset64: valid=%b ready=%b imm=%h tgt=%h ill=%b, required 0 1 0 0 0",
               ov64, rdy64, imm64, tgt64, ill64);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_formats();
    vec_t v[8];
    v = '{
      '{32'hFFF00093, 3'd0, 64'h0,         32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0},
      '{32'hFE000EE3, 3'd2, 64'h100,       32'hFFFFFFFC, 32'h000000FC, 64'hFFFFFFFFFFFFFFFC, 1'b0},
      '{32'h0080006F, 3'd3, 64'hFFFFFFFC,  32'h00000008, 32'h00000004, 64'h0000000000000008, 1'b0},
      '{32'h80000037, 3'd4, 64'h1000,      32'h80000000, 32'h80001000, 64'hFFFFFFFF80000000, 1'b0},
      '{32'h80000037, 3'd7, 64'h2000,      32'h00000000, 32'h00002000, 64'h0000000000000000, 1'b1},
      '{32'hFE112E23, 3'd1, 64'h40,        32'hFFFFFFFC, 32'h0000003C, 64'hFFFFFFFFFFFFFFFC, 1'b0},
      '{32'h800F8000, 3'd5, 64'h10,        32'h0000001F, 32'h0000002F, 64'h000000000000001F, 1'b0},
      '{32'h83F00000, 3'd6, 64'h0,         32'h0000001F, 32'h0000001F, 64'h000000000000003F, 1'b0}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(v[i].instr, v[i].src, v[i].pc);
      n_checks++;
      if ({ov32, ov64, imm32, tgt32, ill32, imm64, ill64} !==
          {1'b1, 1'b1, v[i].imm32, v[i].tgt32, v[i].ill, v[i].imm64, v[i].ill}) begin
        n_fail++;
        $display("FAIL fmt%0d: valid=%b%b imm32=%h tgt32=%h ill=%b imm64=%h ill=%b, required 11 %h %h %b %h %b",
                 i, ov32, ov64, imm32, tgt32, ill32, imm64, ill64,
                 v[i].imm32, v[i].tgt32, v[i].ill, v[i].imm64, v[i].ill);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({ov32, ov64} !== 2'b00) begin
        n_fail++;
        $display("FAIL fmt%0d_empty: out_valid=%b%b, required 00", i, ov32, ov64);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
      n_checks++;
      if ({rdy32, rdy64, ov32, ov64} !== 4'b1111) begin
        n_fail++;
        $display("FAIL stream%0d: ready=%b%b valid=%b%b, required 11 11", i, rdy32, rdy64, ov32, ov64);
      end
    end
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    drain("random");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 64'h10);
    n_checks++;
    if ({rdy32, rdy64} !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_one_held: in_ready=%b%b, required 11", rdy32, rdy64);
    end
    send(32'hFE000EE3, 3'd2, 64'h200);
    n_checks++;
    if ({rdy32, rdy64} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_two_held: in_ready=%b%b, required 00", rdy32, rdy64);
    end
    in_instr = 25'(32'h0080006F >> 7); in_imm_src = 3'd3; pc64 = 64'hFFFFFFFC;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (q32.size() < 1 || q64.size() < 1) begin
        n_fail++;
        $display("FAIL bp_stall%0d: pending=%0d/%0d, required 2/2", c, q32.size(), q64.size());
      end else if ({ov32, ov64, rdy32, imm32, tgt32, imm64, tgt64} !==
                   {1'b1, 1'b1, 1'b0, q32[0].imm[31:0], q32[0].target[31:0], q64[0].imm, q64[0].target}) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid=%b%b ready=%b imm32=%h imm64=%h, required 11 0 %h %h",
                 c, ov32, ov64, rdy32, imm32, imm64, q32[0].imm[31:0], q64[0].imm);
      end
    end
    out_ready = 1'b1;
    send(32'h0080006F, 3'd3, 64'hFFFFFFFC);
    send(32'hDEADB037, 3'd4, 64'h3000);
    drain("bp");
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    send(32'h12345093, 3'd0, 64'h80);
    send(32'h00500093, 3'd0, 64'h90);
    in_instr = 25'(32'hFFF00093 >> 7); in_imm_src = 3'd0; pc64 = 64'h40;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({ov32, ov64, rdy32, rdy64} !== 4'b0011) begin
      n_fail++;
      $display("FAIL flush: valid=%b%b ready=%b%b, required 00 11", ov32, ov64, rdy32, rdy64);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, ov64} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_lost: valid=%b%b, required 00", ov32, ov64);
    end
    send(32'h7FF00093, 3'd0, 64'h4);
    drain("post_flush");

    out_ready = 1'b0;
    send(32'hFFF00093, 3'd7, 64'h5555);
    send(32'h0080006F, 3'd3, 64'h100);
    in_instr = 25'(32'hFE000EE3 >> 7); in_imm_src = 3'd2; pc64 = 64'h20;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ov32, rdy32, imm32, tgt32, ill32, ov64, rdy64, imm64, tgt64, ill64} !==
        {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset: v=%b%b r=%b%b imm=%h/%h tgt=%h/%h ill=%b%b, required all 0, ready 1",
               ov32, ov64, rdy32, rdy64, imm32, imm64, tgt32, tgt64, ill32, ill64);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, ov64} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_lost: valid=%b%b, required 00", ov32, ov64);
    end
    send(32'h00A00093, 3'd0, 64'h8);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline kill.
REQ-005 in_valid  input  1  upstream entry valid.
REQ-006 in_ready  output  1  block accepts entry this cycle.
REQ-007 in_instr  input  25  instruction bits [31:7].
REQ-008 in_imm_src  input  3  immediate format select.
REQ-009 in_pc  input  XLEN  PC of the instruction.
REQ-010 out_valid  output  1  result entry valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_target  output  XLEN  in_pc + out_imm.
REQ-014 out_illegal  output  1  format select was reserved.

Function
REQ-015 Formats SHALL be: 000 I {sx instr[31:20]}; 001 S {sx instr[31:25],instr[11:7]}; 010 B {sx instr[31],instr[7],instr[30:25],instr[11:8],0}; 011 J {sx instr[31],instr[19:12],instr[20],instr[30:21],0}; 100 U {sx instr[31:12],12'b0}.
REQ-016 101 Z SHALL zero-extend instr[19:15] (CSR uimm); 110 SH SHALL zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-017 111 SHALL yield out_imm=0, out_target=in_pc, out_illegal=1; all other codes give out_illegal=0.
REQ-018 "sx" SHALL mean sign extension from instr[31] to full XLEN.
REQ-019 out_target SHALL be XLEN-bit modulo sum; carry-out discarded (wrap-around).
REQ-020 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to out_valid when output stage empty.
REQ-022 Storage SHALL be a 2-entry skid buffer: main (drives outputs) and skid.
REQ-023 in_ready SHALL equal !skid_full, registered; throughput 1/cycle under continuous out_ready.
REQ-024 Input accepted while main full and not draining SHALL go to skid; skid SHALL move to main when main drains.
REQ-025 Simultaneous input and output transfer with skid empty SHALL load main directly, out_valid stays 1.
REQ-026 Entries SHALL leave in acceptance order; no drop, no duplication.
REQ-027 out_* data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 flush=1 SHALL empty both entries next cycle and discard any same-cycle input; in_ready=1 after.
REQ-029 Priority SHALL be rst_n low > flush > normal operation.

Reset
REQ-030 On rst_n=0 at clk edge: out_valid=0, skid empty, in_ready=1, out_imm=0, out_target=0, out_illegal=0.
REQ-031 Reset mid-operation SHALL discard all held entries with no output transfer that cycle.

Structure
REQ-032 Package imm_ext_pkg SHALL hold the 3-bit format codes (I,S,B,J,U,Z,SH,RSV) and a result struct typedef {imm, target, illegal}.
REQ-033 Combinational formatting SHALL live in sub-module imm_ext_fmt (instr, src -> imm, illegal), parametrised by XLEN.
REQ-034 Skid/handshake control SHALL reside in imm_ext_pipe only.

Verification
REQ-035 I: instr 0xFFF00093, src 000, pc 0x0 -> out_imm 0xFFFFFFFF, illegal 0, one cycle later.
REQ-036 B: instr 0xFE000EE3, src 010, pc 0x100 -> out_imm 0xFFFFFFFC, out_target 0x000000FC.
REQ-037 J wrap: instr 0x0080006F, src 011, pc 0xFFFFFFFC -> out_imm 0x8, out_target 0x00000004.
REQ-038 U/XLEN=64: instr 0x80000037, src 100 -> out_imm 0xFFFFFFFF80000000; src 111 -> imm 0, illegal 1.
REQ-039 Backpressure: 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 held, all 4 emerge in order, data stable while stalled.
REQ-040 Flush/reset: 2 entries held, flush with in_valid=1 -> out_valid 0 next cycle, input lost; repeat with rst_n=0 -> all outputs 0.
